// File: rtl/cu_pkg.sv
// Shared encodings for the RV32I single-cycle control unit.
// Opcodes, ALU/immediate selects and the main-decode bundle.
package cu_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // funct3 values that matter to the ALU decoder
    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Class of ALU operation requested by the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc encodings
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Main decoder output bundle
    typedef struct packed {
        logic       regwrite;
        logic [1:0] immsrc;
        logic       alusrc;
        logic       memwrite;
        logic       resultsrc;
        logic       branch;
        logic       jump;
        aluop_e     aluop;
    } main_ctrl_t;

    localparam main_ctrl_t MAIN_NOP = '{
        regwrite:  1'b0,
        immsrc:    IMM_I,
        alusrc:    1'b0,
        memwrite:  1'b0,
        resultsrc: 1'b0,
        branch:    1'b0,
        jump:      1'b0,
        aluop:     ALUOP_ADD
    };

    function automatic logic is_legal(
        input logic [6:0] op
    );
        return (op == OP_LW)  ||
               (op == OP_SW)  ||
               (op == OP_R)   ||
               (op == OP_I)   ||
               (op == OP_BEQ) ||
               (op == OP_JAL);
    endfunction

    // Unsupported opcodes fall through to the all-zero bundle.
    function automatic main_ctrl_t main_decode(
        input logic [6:0] op
    );
        main_ctrl_t c;
        c = MAIN_NOP;
        unique case (1'b1)
            (op == OP_LW): begin
                c.regwrite  = 1'b1;
                c.immsrc    = IMM_I;
                c.alusrc    = 1'b1;
                c.resultsrc = 1'b1;
                c.aluop     = ALUOP_ADD;
            end
            (op == OP_SW): begin
                c.immsrc   = IMM_S;
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            (op == OP_R): begin
                c.regwrite = 1'b1;
                c.aluop    = ALUOP_FUNCT;
            end
            (op == OP_I): begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.aluop    = ALUOP_FUNCT;
            end
            (op == OP_BEQ): begin
                c.immsrc = IMM_B;
                c.branch = 1'b1;
                c.aluop  = ALUOP_SUB;
            end
            (op == OP_JAL): begin
                // No link path: result mux is only ALU/mem.
                c.immsrc = IMM_J;
                c.jump   = 1'b1;
                c.aluop  = ALUOP_ADD;
            end
            default: c = MAIN_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_unit_alu_dec.sv
// ALU decoder: ALUopcode/funct3/opcode[5]/funct7[5] -> ALUControl.
// Ports: aluop, funct3, opcode_5, funct7_5 in; alu_control out.
module alu_dec
    import cu_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [2:0] funct3,
    input  logic       opcode_5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    logic [2:0] funct_ctrl;

    // Subtract only for R-type with funct7[5]; addi
    // carries immediate bits in funct7 and must add.
    always_comb begin
        funct_ctrl = ALU_ADD;
        unique case (1'b1)
            (funct3 == F3_ADDSUB):
                funct_ctrl = (opcode_5 & funct7_5) ?
                             ALU_SUB : ALU_ADD;
            (funct3 == F3_SLT):
                funct_ctrl = ALU_SLT;
            (funct3 == F3_OR):
                funct_ctrl = ALU_OR;
            (funct3 == F3_AND):
                funct_ctrl = ALU_AND;
            default:
                funct_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        unique case (aluop)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            ALUOP_RSVD:  alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main + ALU decoder for the single-cycle RV32I datapath, with a
// sticky illegal-opcode flag. Optional macro: CU_PIPE_OUT_EN.
// Ports:
//   clk, reset (sync, active-high)
//   opcode[6:0], funct7[6:0], funct3[2:0], zero
//   PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite,
//   ALUControl[2:0], ImmSrc[1:0], illegal
// CU_PIPE_OUT_EN defined: decode outputs registered (1-cycle
// latency, cleared by reset). Undefined: outputs combinational.
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    input  logic       zero,
    output logic       PCSrc,
    output logic       ResultSrc,
    output logic       MemWrite,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal
);

    main_ctrl_t mc;
    aluop_e     ALUopcode;
    logic       opcode_5;
    logic       funct7_5;
    logic       legal;
    logic       pcsrc_d;
    logic [2:0] alu_ctrl_d;
    logic       unused_f7;

    always_comb begin
        mc    = main_decode(opcode);
        legal = is_legal(opcode);
    end

    assign ALUopcode = mc.aluop;
    assign opcode_5  = opcode[5];
    assign funct7_5  = funct7[5];
    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    alu_dec u_alu_dec (
        .aluop       (ALUopcode),
        .funct3      (funct3),
        .opcode_5    (opcode_5),
        .funct7_5    (funct7_5),
        .alu_control (alu_ctrl_d)
    );

    // funct3 ignored: every branch opcode acts as beq.
    assign pcsrc_d = (mc.branch & zero) | mc.jump;

    // Reset has priority over a simultaneous bad opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (!legal) begin
            illegal <= 1'b1;
        end
    end

`ifdef CU_PIPE_OUT_EN

    always_ff @(posedge clk) begin
        if (reset) begin
            PCSrc      <= 1'b0;
            ResultSrc  <= 1'b0;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            RegWrite   <= 1'b0;
            ALUControl <= ALU_ADD;
            ImmSrc     <= IMM_I;
        end else begin
            PCSrc      <= pcsrc_d;
            ResultSrc  <= mc.resultsrc;
            MemWrite   <= mc.memwrite;
            ALUSrc     <= mc.alusrc;
            RegWrite   <= mc.regwrite;
            ALUControl <= alu_ctrl_d;
            ImmSrc     <= mc.immsrc;
        end
    end

`else

    // State-changing strobes are masked during reset;
    // the mux selects keep decoding so the datapath settles.
    assign PCSrc      = pcsrc_d & ~reset;
    assign MemWrite   = mc.memwrite & ~reset;
    assign RegWrite   = mc.regwrite & ~reset;
    assign ResultSrc  = mc.resultsrc;
    assign ALUSrc     = mc.alusrc;
    assign ALUControl = alu_ctrl_d;
    assign ImmSrc     = mc.immsrc;

`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit (combinational build).
// Table vectors plus hand sequences for the sticky flag and reset.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       zero;
    logic       PCSrc;
    logic       ResultSrc;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       illegal;

    int checks;
    int failures;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct7     (funct7),
        .funct3     (funct3),
        .zero       (zero),
        .PCSrc      (PCSrc),
        .ResultSrc  (ResultSrc),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       z;
        logic       rst;
        logic [10:0] want;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] want;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    // {PCSrc,ResultSrc,MemWrite,ALUSrc,RegWrite,ALUControl,ImmSrc,illegal}
    function automatic logic [10:0] mk(
        input logic pc, input logic rs, input logic mw,
        input logic as, input logic rw,
        input logic [2:0] alu, input logic [1:0] imm,
        input logic ill
    );
        return {pc, rs, mw, as, rw, alu, imm, ill};
    endfunction

    task automatic addv(
        input string n, input logic [6:0] op, input logic [6:0] f7,
        input logic [2:0] f3, input logic z, input logic rst,
        input logic [10:0] w
    );
        vec_t v;
        v.name = n; v.op = op; v.f7 = f7; v.f3 = f3;
        v.z = z; v.rst = rst; v.want = w;
        vecs.push_back(v);
    endtask

    task automatic drive(
        input string n, input logic [6:0] op, input logic [6:0] f7,
        input logic [2:0] f3, input logic z, input logic rst,
        input logic [10:0] w
    );
        exp_t e;
        opcode = op; funct7 = f7; funct3 = f3;
        zero = z; reset = rst;
        e.name = n; e.want = w;
        sb.push_back(e);
    endtask

    task automatic expect_more(input string n, input logic [10:0] w);
        exp_t e;
        e.name = n; e.want = w;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        logic [10:0] got;
        got = {PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite,
               ALUControl, ImmSrc, illegal};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%b", got);
        end else begin
            e = sb.pop_front();
            if (got !== e.want) begin
                failures++;
                $display("FAIL %s got=%b want=%b (pc rs mw as rw alu imm ill)",
                         e.name, got, e.want);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; opcode = 7'd0; funct7 = 7'd0;
        funct3 = 3'd0; zero = 1'b0;

        addv("lw",        7'b0000011, 7'h00, 3'b000, 0, 0, mk(0,1,0,1,1,3'b000,2'b00,0));
        addv("sw",        7'b0100011, 7'h00, 3'b010, 0, 0, mk(0,0,1,1,0,3'b000,2'b01,0));
        addv("andi",      7'b0010011, 7'h00, 3'b111, 0, 0, mk(0,0,0,1,1,3'b010,2'b00,0));
        addv("addi_f7",   7'b0010011, 7'h20, 3'b000, 0, 0, mk(0,0,0,1,1,3'b000,2'b00,0));
        addv("r_sub",     7'b0110011, 7'h20, 3'b000, 0, 0, mk(0,0,0,0,1,3'b001,2'b00,0));
        addv("r_add",     7'b0110011, 7'h00, 3'b000, 0, 0, mk(0,0,0,0,1,3'b000,2'b00,0));
        addv("r_or",      7'b0110011, 7'h00, 3'b110, 0, 0, mk(0,0,0,0,1,3'b011,2'b00,0));
        addv("r_slt",     7'b0110011, 7'h00, 3'b010, 0, 0, mk(0,0,0,0,1,3'b101,2'b00,0));
        addv("r_and",     7'b0110011, 7'h00, 3'b111, 1, 0, mk(0,0,0,0,1,3'b010,2'b00,0));
        addv("r_xor",     7'b0110011, 7'h00, 3'b100, 0, 0, mk(0,0,0,0,1,3'b000,2'b00,0));
        addv("slti",      7'b0010011, 7'h00, 3'b010, 0, 0, mk(0,0,0,1,1,3'b101,2'b00,0));
        addv("ori",       7'b0010011, 7'h20, 3'b110, 0, 0, mk(0,0,0,1,1,3'b011,2'b00,0));
        addv("beq_f3_z0", 7'b1100011, 7'h00, 3'b010, 0, 0, mk(0,0,0,0,0,3'b001,2'b10,0));
        addv("beq_z1",    7'b1100011, 7'h00, 3'b000, 1, 0, mk(1,0,0,0,0,3'b001,2'b10,0));
        addv("beq_z0",    7'b1100011, 7'h00, 3'b000, 0, 0, mk(0,0,0,0,0,3'b001,2'b10,0));
        addv("jal_z0",    7'b1101111, 7'h00, 3'b011, 0, 0, mk(1,0,0,0,0,3'b000,2'b11,0));
        addv("jal_z1",    7'b1101111, 7'h20, 3'b000, 1, 0, mk(1,0,0,0,0,3'b000,2'b11,0));
        addv("rst_lw",    7'b0000011, 7'h00, 3'b010, 0, 1, mk(0,1,0,1,0,3'b000,2'b00,0));
        addv("rst_sw",    7'b0100011, 7'h00, 3'b010, 0, 1, mk(0,0,0,1,0,3'b000,2'b01,0));
        addv("rst_jal",   7'b1101111, 7'h00, 3'b000, 0, 1, mk(0,0,0,0,0,3'b000,2'b11,0));
        addv("rst_beq",   7'b1100011, 7'h00, 3'b000, 1, 1, mk(0,0,0,0,0,3'b001,2'b10,0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive("reset_state", 7'd0, 7'd0, 3'd0, 0, 1, mk(0,0,0,0,0,3'b000,2'b00,0));
        #1 sample();

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].name, vecs[i].op, vecs[i].f7, vecs[i].f3,
                  vecs[i].z, vecs[i].rst, vecs[i].want);
            #1 sample();
        end

        // Illegal opcode: decode zero now, flag after the edge
        @(negedge clk);
        drive("ill_decode", 7'b0000000, 7'h00, 3'b000, 1, 0, mk(0,0,0,0,0,3'b000,2'b00,0));
        #1 sample();
        @(posedge clk);
        expect_more("ill_set", mk(0,0,0,0,0,3'b000,2'b00,1));
        #1 sample();

        // Sticky across a legal instruction
        @(negedge clk);
        drive("ill_sticky_lw", 7'b0000011, 7'h00, 3'b010, 0, 0, mk(0,1,0,1,1,3'b000,2'b00,1));
        #1 sample();

        // Reset wins over a simultaneous illegal opcode
        @(negedge clk);
        drive("rst_pre_edge", 7'b0000000, 7'h00, 3'b000, 0, 1, mk(0,0,0,0,0,3'b000,2'b00,1));
        #1 sample();
        @(posedge clk);
        expect_more("rst_clears_ill", mk(0,0,0,0,0,3'b000,2'b00,0));
        #1 sample();

        @(negedge clk);
        drive("rst_hold_lw", 7'b0000011, 7'h00, 3'b010, 1, 1, mk(0,1,0,1,0,3'b000,2'b00,0));
        #1 sample();

        // Any funct3 on the branch opcode acts as beq
        @(negedge clk);
        drive("bne_as_beq", 7'b1100011, 7'h00, 3'b101, 1, 0, mk(1,0,0,0,0,3'b001,2'b10,0));
        #1 sample();

        @(negedge clk);
        drive("ill_7f", 7'b1111111, 7'h7f, 3'b111, 1, 0, mk(0,0,0,0,0,3'b000,2'b00,0));
        #1 sample();
        @(posedge clk);
        expect_more("ill_7f_set", mk(0,0,0,0,0,3'b000,2'b00,1));
        #1 sample();

        @(negedge clk);
        drive("rst_andi", 7'b0010011, 7'h00, 3'b111, 0, 1, mk(0,0,0,1,0,3'b010,2'b00,1));
        #1 sample();
        @(posedge clk);
        expect_more("rst_andi_clr", mk(0,0,0,1,0,3'b010,2'b00,0));
        #1 sample();

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
